// File: rtl/mem_sparse_responder.sv
// mem_sparse_responder: responder side of the single-cycle write/read strobe
// memory interface, backed by a small fully-associative sparse store of
// ENTRIES tagged slots. Reports read misses, capacity overflow (dropped
// writes) and write+read protocol violations.
//
// Optional feature macro: PARITY_INJECT_EN
//   When defined, adds an inject_err input and a stored parity bit per slot
//   (written as ^data_in ^ inject_err), and reads return that stored parity.
//   When undefined, parity is recomputed from the stored data at read time.
module mem_sparse_responder #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int ENTRIES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write,
    input  logic              read,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
`ifdef PARITY_INJECT_EN
    input  logic              inject_err,
`endif
    output logic [DATA_W:0]   data_out,
    output logic              data_valid,
    output logic              read_miss,
    output logic              full,
    output logic              write_drop,
    output logic              proto_err,
    output logic [7:0]        drop_cnt
);

    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    // Slot state: only the valid bits carry reset; tags/data are qualified by them.
    logic [ENTRIES-1:0] valid_q;
    logic [ADDR_W-1:0]  tag_q  [ENTRIES];
    logic [DATA_W-1:0]  data_q [ENTRIES];
`ifdef PARITY_INJECT_EN
    logic [ENTRIES-1:0] par_q;
`endif

    logic [ENTRIES-1:0] hit_vec;
    logic [IDX_W-1:0]   hit_idx;
    logic [IDX_W-1:0]   free_idx;
    logic               any_hit;
    logic               any_free;
    logic               wr_store;
    logic               wr_drop;
    logic               rd_en;
    logic [IDX_W-1:0]   wr_idx;
    logic [ENTRIES-1:0] alloc_vec;
    logic [ENTRIES-1:0] valid_next;
    logic [DATA_W-1:0]  rd_data;
    logic               rd_par;

    // Parallel tag compare and lowest-index free-slot search.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        hit_vec  = '0;
        hit_idx  = '0;
        free_idx = '0;
        any_free = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && (tag_q[i] == address)) begin
                hit_vec[i] = 1'b1;
                hit_idx    = i[IDX_W-1:0];
            end
        end
        // Descending scan so the last assignment is the lowest invalid index.
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_idx = i[IDX_W-1:0];
                any_free = 1'b1;
            end
        end
    end

    assign any_hit = |hit_vec;

    // Write decode: a hit always wins over allocation, so tags stay unique.
    always_comb begin
        rd_en      = read && !write;
        wr_store   = write && (any_hit || any_free);
        wr_drop    = write && !any_hit && !any_free;
        wr_idx     = any_hit ? hit_idx : free_idx;
        alloc_vec  = '0;
        if (write && !any_hit && any_free) begin
            alloc_vec[free_idx] = 1'b1;
        end
        valid_next = valid_q | alloc_vec;
    end

    // Read-side data and parity for the hit slot.
    always_comb begin
        rd_data = data_q[hit_idx];
`ifdef PARITY_INJECT_EN
        rd_par  = par_q[hit_idx];
`else
        rd_par  = ^rd_data;
`endif
    end

    // Slot payload storage (tag, data, optional parity).
    // NOTE: storage arrays are deliberately not reset; valid_q alone marks slot contents as meaningful.
    always_ff @(posedge clk) begin
        if (wr_store) begin
            tag_q[wr_idx]  <= address;
            data_q[wr_idx] <= data_in;
`ifdef PARITY_INJECT_EN
            par_q[wr_idx]  <= (^data_in) ^ inject_err;
`endif
        end
    end

    // Valid bits, status flags and registered read/write responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= '0;
            full       <= 1'b0;
            drop_cnt   <= 8'd0;
            data_out   <= '0;
            data_valid <= 1'b0;
            read_miss  <= 1'b0;
            write_drop <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            valid_q    <= valid_next;
            full       <= &valid_next;
            data_valid <= rd_en;
            write_drop <= wr_drop;
            proto_err  <= write && read;
            if (wr_drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
            if (rd_en) begin
                read_miss <= !any_hit;
                data_out  <= any_hit ? {rd_par, rd_data} : '0;
            end else begin
                read_miss <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_sparse_responder.sv
// Self-checking bench for mem_sparse_responder. Read responses are predicted
// from a reference model of the sparse store and queued when the read is
// driven; a negedge monitor pops and compares them when data_valid appears.
module tb_mem_sparse_responder;

    localparam int ENTRIES = 8;

    logic        clk;
    logic        rst_n;
    logic        write;
    logic        read;
    logic [15:0] address;
    logic [7:0]  data_in;
`ifdef PARITY_INJECT_EN
    logic        inject_err;
`endif
    logic [8:0]  data_out;
    logic        data_valid;
    logic        read_miss;
    logic        full;
    logic        write_drop;
    logic        proto_err;
    logic [7:0]  drop_cnt;

    mem_sparse_responder #(
        .ADDR_W (16),
        .DATA_W (8),
        .ENTRIES(ENTRIES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .write     (write),
        .read      (read),
        .address   (address),
        .data_in   (data_in),
`ifdef PARITY_INJECT_EN
        .inject_err(inject_err),
`endif
        .data_out  (data_out),
        .data_valid(data_valid),
        .read_miss (read_miss),
        .full      (full),
        .write_drop(write_drop),
        .proto_err (proto_err),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] data;
        logic       miss;
    } exp_t;

    exp_t        sb [$];
    logic [7:0]  m_data [logic [15:0]];
    logic        m_par  [logic [15:0]];
    int          m_drops;
    int          n_checks;
    int          n_pass;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Scoreboard monitor: every data_valid must match the oldest queued prediction.
    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            check("sb_expected_resp", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("sb_data_out", data_out, e.data);
                check("sb_read_miss", read_miss, e.miss);
            end
        end
    end

    // One operation: drive at negedge, update the model, then wait to the next
    // negedge where the registered response/pulses of this op are visible.
    task automatic op(input logic wr, input logic rd, input logic [15:0] addr,
                      input logic [7:0] din, input logic inj);
        logic exp_valid;
        logic exp_drop;
        exp_t e;
        write     = wr;
        read      = rd;
        address   = addr;
        data_in   = din;
`ifdef PARITY_INJECT_EN
        inject_err = inj;
`endif
        exp_valid = rd && !wr;
        exp_drop  = 1'b0;
        if (exp_valid) begin
            if (m_data.exists(addr)) begin
                e.data = {m_par[addr], m_data[addr]};
                e.miss = 1'b0;
            end else begin
                e.data = 9'h000;
                e.miss = 1'b1;
            end
            sb.push_back(e);
        end
        if (wr) begin
            if (m_data.exists(addr) || (m_data.num() < ENTRIES)) begin
                m_data[addr] = din;
                m_par[addr]  = (^din) ^ inj;
            end else begin
                exp_drop = 1'b1;
                if (m_drops < 255) m_drops++;
            end
        end
        @(negedge clk);
        write = 1'b0;
        read  = 1'b0;
        check("data_valid", data_valid, exp_valid);
        check("write_drop", write_drop, exp_drop);
        check("proto_err", proto_err, wr && rd);
        check("drop_cnt", drop_cnt, m_drops);
    endtask

    task automatic idle(input int n);
        write = 1'b0;
        read  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_data.delete();
        m_par.delete();
        m_drops = 0;
        @(negedge clk);
        check("rst_data_out", data_out, 9'h000);
        check("rst_data_valid", data_valid, 0);
        check("rst_read_miss", read_miss, 0);
        check("rst_write_drop", write_drop, 0);
        check("rst_proto_err", proto_err, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_full", full, 0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    function automatic logic [15:0] fresh_addr();
        logic [15:0] a;
        do begin
            a = 16'($urandom_range(16'hFFF0, 16'h0100));
        end while (m_data.exists(a) || a == 16'h1234 || a == 16'hA5A5);
        return a;
    endfunction

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] addrs [8];
        logic [7:0]  datas [8];
        int          order [6];

        n_checks = 0;
        n_pass   = 0;
        m_drops  = 0;
        rst_n    = 1'b0;
        write    = 1'b0;
        read     = 1'b0;
        address  = '0;
        data_in  = '0;
`ifdef PARITY_INJECT_EN
        inject_err = 1'b0;
`endif
        #3;
        do_reset();

        // Read of an empty store misses with zero data.
        op(0, 1, 16'h1234, 8'h00, 0);
        check("miss_lit_data", data_out, 9'h000);
        check("miss_lit_flag", read_miss, 1);
        check("miss_full", full, 0);

        // Write then back-to-back read: even and odd parity cases.
        op(1, 0, 16'hA5A5, 8'h3C, 0);
        op(0, 1, 16'hA5A5, 8'h00, 0);
        check("a5a5_lit", data_out, 9'h03C);
        op(1, 0, 16'h0001, 8'h07, 0);
        op(0, 1, 16'h0001, 8'h00, 0);
        check("0001_lit", data_out, 9'h107);
        idle(2);
        check("data_out_hold", data_out, 9'h107);

        // Six random entries into a clean store, read back shuffled.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            addrs[i] = fresh_addr();
            datas[i] = 8'($urandom);
            op(1, 0, addrs[i], datas[i], 0);
        end
        for (int i = 0; i < 6; i++) order[i] = i;
        for (int i = 5; i > 0; i--) begin
            int j;
            int t;
            j = $urandom_range(i, 0);
            t = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        for (int i = 0; i < 6; i++) begin
            op(0, 1, addrs[order[i]], 8'h00, 0);
            check("rand_rd_miss", read_miss, 0);
            check("rand_rd_data", data_out[7:0], datas[order[i]]);
        end
        check("rand_not_full", full, 0);

        // Fill the last two slots, then overflow.
        for (int i = 6; i < 8; i++) begin
            addrs[i] = fresh_addr();
            datas[i] = 8'($urandom);
            op(1, 0, addrs[i], datas[i], 0);
        end
        idle(1);
        check("fill_full", full, 1);
        op(1, 0, 16'hFFFF, 8'hAA, 0);
        check("drop_lit_cnt", drop_cnt, 1);
        op(0, 1, 16'hFFFF, 8'h00, 0);
        op(1, 0, addrs[3], 8'hE1, 0);
        op(0, 1, addrs[3], 8'h00, 0);
        check("overwrite_lit", data_out, 9'h0E1);
        for (int i = 0; i < 259; i++) begin
            op(1, 0, 16'hFFFF, 8'(i), 0);
        end
        check("drop_sat_lit", drop_cnt, 255);
        check("drop_full_hold", full, 1);

        // Simultaneous write and read: write done, read ignored.
        do_reset();
        op(1, 1, 16'h0010, 8'h55, 0);
        op(0, 1, 16'h0010, 8'h00, 0);
        check("proto_rd_lit", data_out, 9'h055);

`ifdef PARITY_INJECT_EN
        // Injected parity error is stored and returned; a hit write refreshes it.
        op(1, 0, 16'h0020, 8'h01, 1);
        op(0, 1, 16'h0020, 8'h00, 0);
        check("inject_lit", data_out, 9'h001);
        op(1, 0, 16'h0020, 8'h01, 0);
        op(0, 1, 16'h0020, 8'h00, 0);
        check("refresh_lit", data_out, 9'h101);
`else
        op(1, 0, 16'h0020, 8'h01, 0);
        op(0, 1, 16'h0020, 8'h00, 0);
        check("0020_lit", data_out, 9'h101);
`endif

        // Reset asserted mid-read: the response is cancelled and the store cleared.
        read    = 1'b1;
        address = 16'h0010;
        #2;
        rst_n   = 1'b0;
        m_data.delete();
        m_par.delete();
        m_drops = 0;
        @(negedge clk);
        read = 1'b0;
        check("rst_mid_valid", data_valid, 0);
        check("rst_mid_data", data_out, 9'h000);
        rst_n = 1'b1;
        @(negedge clk);
        op(0, 1, 16'h0010, 8'h00, 0);
        check("rst_mid_miss10", read_miss, 1);
        op(0, 1, 16'h0020, 8'h00, 0);
        check("rst_mid_miss20", read_miss, 1);
        op(0, 1, 16'hA5A5, 8'h00, 0);

        idle(2);
        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_sparse_responder.md
Name: mem_sparse_responder

Overview:
- Responder side of the single-cycle write/read strobe memory interface (16-bit address, 8-bit write data, 9-bit read data with parity).
- Implements a small fully-associative sparse store: ENTRIES tagged slots instead of a full 64K array.
- Serves random-address traffic from initiators and benches driving write/read strobes.
- Reports misses, capacity overflow and protocol violations.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 8, data width; data_out is DATA_W+1 bits wide.
- ENTRIES, 8, number of tagged slots (2..32).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- write  in  1  write strobe, sampled at posedge
- read  in  1  read strobe, sampled at posedge
- address  in  ADDR_W  target address
- data_in  in  DATA_W  write data
- data_out  out  DATA_W+1  {parity, data}; parity = XOR of data bits (even parity over 9 bits)
- data_valid  out  1  one-cycle pulse, data_out valid
- read_miss  out  1  qualifies data_valid: address not stored, data_out = 0
- full  out  1  all slots valid
- write_drop  out  1  one-cycle pulse, write miss rejected because store is full
- proto_err  out  1  one-cycle pulse, write and read asserted in the same cycle
- drop_cnt  out  8  saturating count of dropped writes

Behaviour:
- Reset (async assert, sync-free deassert):
  - all slot valid bits = 0.
  - data_out = 0, data_valid = 0, read_miss = 0, write_drop = 0, proto_err = 0, drop_cnt = 0.
  - full = 0.
- Slot state per entry: valid, tag[ADDR_W], data[DATA_W]. Lookup is a parallel compare of address against all valid tags.
- Write (write=1, read=0) at posedge:
  - Hit: overwrite the slot's data.
  - Miss, not full: allocate the lowest-index invalid slot; set valid, tag, data.
  - Miss, full: no state change; write_drop=1 next cycle; drop_cnt += 1, saturating at 255.
  - No response pulse on a successful write.
- Read (read=1, write=0) at posedge:
  - Latency 1 cycle: data_valid=1 the following cycle.
  - Hit: data_out = {^data, data}, read_miss = 0.
  - Miss: data_out = 0, read_miss = 1.
  - data_out holds its value after data_valid drops, until the next read response.
- Back-to-back: one op per cycle, no stalls. A read in cycle N+1 of an address written in cycle N returns the new data (write completes at posedge N).
- Write and read together: the write is performed as above, the read is ignored (no data_valid), and proto_err=1 next cycle.
- full is registered: it equals (all valid) and updates the cycle after the allocating write.
- Duplicate tags never exist; a hit always wins over allocation.
- Reset mid-operation: any pending response is cancelled and the store is cleared.
- Address and data are don't-care when neither strobe is set.

Optional Feature:
- Macro: PARITY_INJECT_EN.
- When defined:
  - Adds input port inject_err (1 bit).
  - A stored parity bit is added per slot, computed at write time as ^data_in XOR inject_err.
  - Reads return the stored parity, not a recomputed one.
  - A hit write refreshes the parity.
- When undefined:
  - No inject_err port and no stored parity bits.
  - Parity is computed combinationally from the stored data at read.

Test Plan:
- Reset, then read 16'h1234 -> one cycle later data_valid=1, read_miss=1, data_out=9'h000; drop_cnt=0, full=0.
- Write 16'hA5A5<-8'h3C, then read 16'hA5A5 -> data_out=9'h03C (parity 0); write 16'h0001<-8'h07, read it -> data_out=9'h107.
- Write 6 random addresses/data, then read back in shuffled order -> every data_out[7:0] matches the written data, zero read_miss, full=0.
- Fill 8 distinct addresses (full=1), then write a new address 16'hFFFF -> write_drop pulse, drop_cnt=1; overwrite an existing address -> no drop, new data read back; 260 drops -> drop_cnt=255.
- write=read=1 on 16'h0010 with 8'h55 -> proto_err pulse, no data_valid; a subsequent read returns 9'h055.
- With PARITY_INJECT_EN: write 16'h0020<-8'h01 with inject_err=1 -> read returns 9'h001 (flipped parity); assert rst_n low mid-read -> no data_valid, all entries read as miss.
